// File: rtl/toom_8_pointwise.sv
// rtl/toom_8_pointwise.sv - Toom-8 evaluation and pointwise multiply, 2-stage pipeline
module toom_8_pointwise #(
  parameter int LIMB_W    = 128,
  parameter int NUM_LIMBS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1023:0]       X,
  input  logic [1023:0]       Y,
  output logic [2047:0]       product,
  output logic signed [257:0] p0,
  output logic signed [263:0] p1,
  output logic signed [263:0] p2,
  output logic signed [277:0] p3,
  output logic signed [277:0] p4,
  output logic signed [287:0] p5,
  output logic signed [287:0] p6,
  output logic signed [295:0] p7,
  output logic signed [295:0] p8,
  output logic signed [297:0] p9,
  output logic signed [297:0] p10,
  output logic signed [299:0] p11,
  output logic signed [299:0] p12,
  output logic signed [309:0] p13,
  output logic signed [257:0] pinf
);

  localparam int OPW  = LIMB_W * NUM_LIMBS;
  // |A(7)| < 2^148, so 150 signed bits leave headroom for every point.
  localparam int EW   = 150;
  localparam int NPTS = 15;

  // Zero-extend limb i of an operand into the signed evaluation width.
  function automatic logic signed [EW-1:0] limb_ext(input logic [OPW-1:0] v, input int i);
    return $signed({{(EW-LIMB_W){1'b0}}, v[i*LIMB_W +: LIMB_W]});
  endfunction

  // Multiply by a small constant 0..7 using shifts and adds only.
  function automatic logic signed [EW-1:0] mul_k(input logic signed [EW-1:0] v, input int m);
    logic signed [EW-1:0] r;
    case (m)
      0:       r = '0;
      1:       r = v;
      2:       r = v <<< 1;
      3:       r = (v <<< 1) + v;
      4:       r = v <<< 2;
      5:       r = (v <<< 2) + v;
      6:       r = (v <<< 2) + (v <<< 1);
      7:       r = (v <<< 3) - v;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Horner evaluation at integer point k in -6..7; negative k negates each step.
  function automatic logic signed [EW-1:0] eval_poly(input logic [OPW-1:0] v, input int k);
    logic signed [EW-1:0] acc;
    acc = limb_ext(v, NUM_LIMBS-1);
    for (int i = NUM_LIMBS-2; i >= 0; i--) begin
      if (k < 0) acc = limb_ext(v, i) - mul_k(acc, -k);
      else       acc = limb_ext(v, i) + mul_k(acc, k);
    end
    return acc;
  endfunction

  // Point index j -> evaluation point: 0, +1, -1, +2, -2, ... , +7.
  function automatic int point_of(input int j);
    if (j == 0)          return 0;
    else if (j % 2 == 1) return (j + 1) / 2;
    else                 return -(j / 2);
  endfunction

  logic signed [EW-1:0] ea_d [NPTS];
  logic signed [EW-1:0] ea_q [NPTS];
  logic signed [EW-1:0] eb_d [NPTS];
  logic signed [EW-1:0] eb_q [NPTS];
  logic [OPW-1:0]       x_d, x_q, y_d, y_q;

  logic [2*OPW-1:0]     product_d, product_q;
  logic signed [257:0]  p0_d, p0_q, pinf_d, pinf_q;
  logic signed [263:0]  p1_d, p1_q, p2_d, p2_q;
  logic signed [277:0]  p3_d, p3_q, p4_d, p4_q;
  logic signed [287:0]  p5_d, p5_q, p6_d, p6_q;
  logic signed [295:0]  p7_d, p7_q, p8_d, p8_q;
  logic signed [297:0]  p9_d, p9_q, p10_d, p10_q;
  logic signed [299:0]  p11_d, p11_q, p12_d, p12_q;
  logic signed [309:0]  p13_d, p13_q;

  // Stage 1 next-state: evaluate both operands at all 15 points.
  always_comb begin
    for (int j = 0; j < NPTS-1; j++) begin
      ea_d[j] = eval_poly(X, point_of(j));
      eb_d[j] = eval_poly(Y, point_of(j));
    end
    ea_d[NPTS-1] = limb_ext(X, NUM_LIMBS-1);
    eb_d[NPTS-1] = limb_ext(Y, NUM_LIMBS-1);
    x_d = X;
    y_d = Y;
  end

  // Stage 2 next-state: pointwise products computed directly at port width (true value always fits).
  always_comb begin
    p0_d      = 258'(ea_q[0])  * 258'(eb_q[0]);
    p1_d      = 264'(ea_q[1])  * 264'(eb_q[1]);
    p2_d      = 264'(ea_q[2])  * 264'(eb_q[2]);
    p3_d      = 278'(ea_q[3])  * 278'(eb_q[3]);
    p4_d      = 278'(ea_q[4])  * 278'(eb_q[4]);
    p5_d      = 288'(ea_q[5])  * 288'(eb_q[5]);
    p6_d      = 288'(ea_q[6])  * 288'(eb_q[6]);
    p7_d      = 296'(ea_q[7])  * 296'(eb_q[7]);
    p8_d      = 296'(ea_q[8])  * 296'(eb_q[8]);
    p9_d      = 298'(ea_q[9])  * 298'(eb_q[9]);
    p10_d     = 298'(ea_q[10]) * 298'(eb_q[10]);
    p11_d     = 300'(ea_q[11]) * 300'(eb_q[11]);
    p12_d     = 300'(ea_q[12]) * 300'(eb_q[12]);
    p13_d     = 310'(ea_q[13]) * 310'(eb_q[13]);
    pinf_d    = 258'(ea_q[14]) * 258'(eb_q[14]);
    product_d = {{OPW{1'b0}}, x_q} * {{OPW{1'b0}}, y_q};
  end

  // Pipeline registers for both stages; reset flushes everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NPTS; j++) begin
        ea_q[j] <= '0;
        eb_q[j] <= '0;
      end
      x_q <= '0;  y_q <= '0;
      product_q <= '0;
      p0_q <= '0;  p1_q <= '0;  p2_q <= '0;  p3_q <= '0;  p4_q <= '0;
      p5_q <= '0;  p6_q <= '0;  p7_q <= '0;  p8_q <= '0;  p9_q <= '0;
      p10_q <= '0; p11_q <= '0; p12_q <= '0; p13_q <= '0; pinf_q <= '0;
    end else begin
      for (int j = 0; j < NPTS; j++) begin
        ea_q[j] <= ea_d[j];
        eb_q[j] <= eb_d[j];
      end
      x_q <= x_d;  y_q <= y_d;
      product_q <= product_d;
      p0_q <= p0_d;  p1_q <= p1_d;  p2_q <= p2_d;  p3_q <= p3_d;  p4_q <= p4_d;
      p5_q <= p5_d;  p6_q <= p6_d;  p7_q <= p7_d;  p8_q <= p8_d;  p9_q <= p9_d;
      p10_q <= p10_d; p11_q <= p11_d; p12_q <= p12_d; p13_q <= p13_d; pinf_q <= pinf_d;
    end
  end

  assign product = product_q;
  assign p0   = p0_q;
  assign p1   = p1_q;
  assign p2   = p2_q;
  assign p3   = p3_q;
  assign p4   = p4_q;
  assign p5   = p5_q;
  assign p6   = p6_q;
  assign p7   = p7_q;
  assign p8   = p8_q;
  assign p9   = p9_q;
  assign p10  = p10_q;
  assign p11  = p11_q;
  assign p12  = p12_q;
  assign p13  = p13_q;
  assign pinf = pinf_q;

endmodule

// File: tb/tb_toom_8_pointwise.sv
// tb/tb_toom_8_pointwise.sv - randomized model-checked bench for toom_8_pointwise
module tb_toom_8_pointwise;

  logic                clk = 1'b0;
  logic                rst;
  logic [1023:0]       X, Y;
  logic [2047:0]       product;
  logic signed [257:0] p0, pinf;
  logic signed [263:0] p1, p2;
  logic signed [277:0] p3, p4;
  logic signed [287:0] p5, p6;
  logic signed [295:0] p7, p8;
  logic signed [297:0] p9, p10;
  logic signed [299:0] p11, p12;
  logic signed [309:0] p13;

  int errors = 0;
  int checks = 0;

  toom_8_pointwise dut (
    .clk(clk), .rst(rst), .X(X), .Y(Y), .product(product),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6),
    .p7(p7), .p8(p8), .p9(p9), .p10(p10), .p11(p11), .p12(p12),
    .p13(p13), .pinf(pinf)
  );

  always #5 clk = ~clk;

  logic signed [319:0] got [15];
  assign got[0]  = p0;   assign got[1]  = p1;   assign got[2]  = p2;
  assign got[3]  = p3;   assign got[4]  = p4;   assign got[5]  = p5;
  assign got[6]  = p6;   assign got[7]  = p7;   assign got[8]  = p8;
  assign got[9]  = p9;   assign got[10] = p10;  assign got[11] = p11;
  assign got[12] = p12;  assign got[13] = p13;  assign got[14] = pinf;

  localparam int PTS [14] = '{0, 1, -1, 2, -2, 3, -3, 4, -4, 5, -5, 6, -6, 7};

  // A(k) = sum a_i * k^i, straight power series.
  function automatic logic signed [159:0] poly_at(input logic [1023:0] v, input int k);
    logic signed [159:0] acc, pw, kk;
    acc = '0;
    pw  = 160'sd1;
    kk  = k;
    for (int i = 0; i < 8; i++) begin
      acc = acc + $signed({32'b0, v[i*128 +: 128]}) * pw;
      pw  = pw * kk;
    end
    return acc;
  endfunction

  function automatic logic signed [319:0] model_point(input logic [1023:0] a, input logic [1023:0] b, input int j);
    logic signed [319:0] ea, eb;
    if (j == 14) begin
      ea = $signed({192'b0, a[1023:896]});
      eb = $signed({192'b0, b[1023:896]});
    end else begin
      ea = poly_at(a, PTS[j]);
      eb = poly_at(b, PTS[j]);
    end
    return ea * eb;
  endfunction

  task automatic chk(input string name, input logic signed [319:0] g, input logic signed [319:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, g, e);
    end
  endtask

  task automatic chk_prod(input string name, input logic [2047:0] g, input logic [2047:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got low256 %h expected low256 %h", name, g[255:0], e[255:0]);
    end
  endtask

  // Reference pipeline: output after edge n = f(inputs at edge n-1), zeroed by reset.
  logic signed [319:0] exp_p [15];
  logic [2047:0]       exp_prod;
  logic [1023:0]       px = '0, py = '0;
  bit                  started = 0;

  always @(posedge clk) begin
    for (int j = 0; j < 15; j++) exp_p[j] = rst ? '0 : model_point(px, py, j);
    exp_prod = rst ? '0 : {1024'b0, px} * {1024'b0, py};
    px = rst ? '0 : X;
    py = rst ? '0 : Y;
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int j = 0; j < 15; j++) chk($sformatf("model_p%0d", j), got[j], exp_p[j]);
      chk_prod("model_product", product, exp_prod);
    end
  end

  function automatic logic [1023:0] limbs8(input int a7, a6, a5, a4, a3, a2, a1, a0);
    logic [1023:0] v;
    v = '0;
    v[0*128 +: 128] = 128'(a0); v[1*128 +: 128] = 128'(a1);
    v[2*128 +: 128] = 128'(a2); v[3*128 +: 128] = 128'(a3);
    v[4*128 +: 128] = 128'(a4); v[5*128 +: 128] = 128'(a5);
    v[6*128 +: 128] = 128'(a6); v[7*128 +: 128] = 128'(a7);
    return v;
  endfunction

  // Random operand; each limb is zero, all-ones, small or fully random.
  function automatic logic [1023:0] rand_op();
    logic [1023:0] v;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0: v[i*128 +: 128] = '0;
        1: v[i*128 +: 128] = '1;
        2: v[i*128 +: 128] = 128'($urandom_range(0, 1000));
        default: for (int w = 0; w < 4; w++) v[i*128 + w*32 +: 32] = $urandom;
      endcase
    end
    return v;
  endfunction

  task automatic drive(input logic r, input logic [1023:0] a, input logic [1023:0] b);
    rst = r;
    X = a;
    Y = b;
    @(posedge clk);
    #1;
  endtask

  logic [1023:0]       v, w;
  logic [2047:0]       e_prod;
  logic signed [319:0] m, lim;

  initial begin
    rst = 1'b1;
    X = rand_op();
    Y = rand_op();
    drive(1'b1, rand_op(), rand_op());
    drive(1'b1, rand_op(), rand_op());
    @(negedge clk);
    chk("reset_p0", got[0], '0);
    chk("reset_p13", got[13], '0);
    chk_prod("reset_product", product, '0);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, '0);

    // Small limbs.
    v = limbs8(8, 7, 6, 5, 4, 3, 2, 253);
    drive(1'b0, v, v);
    drive(1'b0, v, v);
    @(negedge clk);
    chk("small_p0", got[0], 320'sd64009);
    chk("small_p1", got[1], 320'sd82944);
    chk("small_p2", got[2], 320'sd61504);
    chk("small_p3", got[3], 320'sd4182025);
    chk("small_p4", got[4], 320'sd210681);
    chk("small_p5", got[5], 320'sd617820736);
    chk("small_pinf", got[14], 320'sd64);
    chk("small_prod_lo", $signed({192'b0, product[127:0]}), 320'sd64009);

    // Negative evaluations: a7=1, b0=1.
    v = limbs8(1, 0, 0, 0, 0, 0, 0, 0);
    w = limbs8(0, 0, 0, 0, 0, 0, 0, 1);
    drive(1'b0, v, w);
    drive(1'b0, v, w);
    @(negedge clk);
    chk("neg_p2", got[2], -320'sd1);
    chk("neg_p4", got[4], -320'sd128);
    chk("neg_p1", got[1], 320'sd1);
    chk("neg_p0", got[0], '0);
    chk("neg_pinf", got[14], '0);
    e_prod = '0;
    e_prod[896] = 1'b1;
    chk_prod("neg_product", product, e_prod);

    // All-ones operands.
    v = '1;
    drive(1'b0, v, v);
    drive(1'b0, v, v);
    @(negedge clk);
    lim = {192'b0, {128{1'b1}}};
    m = 320'sd960800;
    m = m * m * lim * lim;
    chk("ones_p2", got[2], '0);
    chk("ones_p13", got[13], m);
    chk("ones_p13_pos", {319'b0, got[13] > 0}, 320'sd1);
    e_prod = ({2048{1'b1}} << 1025) | 2048'd1;
    chk_prod("ones_product", product, e_prod);

    // Throughput: new operands every cycle.
    for (int i = 0; i < 12; i++) drive(1'b0, rand_op(), rand_op());

    // Reset mid-stream.
    drive(1'b0, rand_op(), rand_op());
    drive(1'b1, rand_op(), rand_op());
    @(negedge clk);
    chk("midrst_p7", got[7], '0);
    chk_prod("midrst_product", product, '0);
    for (int i = 0; i < 6; i++) drive(1'b0, rand_op(), rand_op());

    // Long random run with sporadic resets.
    for (int i = 0; i < 60; i++) drive($urandom_range(0, 15) == 0, rand_op(), rand_op());
    drive(1'b0, '0, '0);
    drive(1'b0, '0, '0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
